// File: rtl/axi_id_remap.sv
// AXI ID remapper: folds wide upstream IDs onto a small table of
// downstream IDs, tracking outstanding transactions per entry.
module axi_id_remap #(
  parameter int IN_ID_WIDTH  = 6,
  parameter int OUT_ID_WIDTH = 2,
  parameter int CNT_WIDTH    = 3,
  parameter int REQ_WIDTH    = 64,
  parameter int RSP_WIDTH    = 66
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    up_req_valid,
  output logic                    up_req_ready,
  input  logic [IN_ID_WIDTH-1:0]  up_req_id,
  input  logic [REQ_WIDTH-1:0]    up_req_data,
  output logic                    dn_req_valid,
  input  logic                    dn_req_ready,
  output logic [OUT_ID_WIDTH-1:0] dn_req_id,
  output logic [REQ_WIDTH-1:0]    dn_req_data,
  input  logic                    dn_rsp_valid,
  output logic                    dn_rsp_ready,
  input  logic [OUT_ID_WIDTH-1:0] dn_rsp_id,
  input  logic                    dn_rsp_last,
  input  logic [RSP_WIDTH-1:0]    dn_rsp_data,
  output logic                    up_rsp_valid,
  input  logic                    up_rsp_ready,
  output logic [IN_ID_WIDTH-1:0]  up_rsp_id,
  output logic                    up_rsp_last,
  output logic [RSP_WIDTH-1:0]    up_rsp_data,
  output logic                    bad_rsp
);

  localparam int N = 2 ** OUT_ID_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CMAX = '1;

  logic [CNT_WIDTH-1:0]    cnt_q [N];
  logic [IN_ID_WIDTH-1:0]  sid_q [N];
  logic                    bad_q;

  logic                    hit;
  logic                    free;
  logic [OUT_ID_WIDTH-1:0] hit_idx;
  logic [OUT_ID_WIDTH-1:0] free_idx;
  logic [OUT_ID_WIDTH-1:0] sel;
  logic                    accept_ok;
  logic                    req_hs;
  logic                    rsp_hs;

  // Search the table: matching active entry, else lowest idle entry.
  // Scanning downward leaves the lowest index as the final winner.
  always_comb begin
    hit      = 1'b0;
    free     = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (cnt_q[i] != '0 && sid_q[i] == up_req_id) begin
        hit     = 1'b1;
        hit_idx = OUT_ID_WIDTH'(i);
      end
      if (cnt_q[i] == '0) begin
        free     = 1'b1;
        free_idx = OUT_ID_WIDTH'(i);
      end
    end
  end

  // Admission depends only on table state, never on dn_req_ready.
  always_comb begin
    sel       = hit ? hit_idx : free_idx;
    accept_ok = rstn & (hit ? (cnt_q[hit_idx] != CMAX) : free);
  end

  assign dn_req_valid = up_req_valid & accept_ok;
  assign up_req_ready = dn_req_ready & accept_ok;
  assign dn_req_id    = sel;
  assign dn_req_data  = up_req_data;

  assign up_rsp_valid = dn_rsp_valid;
  assign dn_rsp_ready = up_rsp_ready;
  assign up_rsp_id    = sid_q[dn_rsp_id];
  assign up_rsp_last  = dn_rsp_last;
  assign up_rsp_data  = dn_rsp_data;
  assign bad_rsp      = bad_q;

  assign req_hs = up_req_valid & dn_req_ready & accept_ok;
  assign rsp_hs = dn_rsp_valid & up_rsp_ready;

  // Table update: allocate/increment on request, retire on last beat.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
        sid_q[i] <= '0;
      end
      bad_q <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        logic inc;
        logic dec;
        inc = req_hs && sel == OUT_ID_WIDTH'(i);
        dec = rsp_hs && dn_rsp_last &&
              dn_rsp_id == OUT_ID_WIDTH'(i) &&
              cnt_q[i] != '0;
        if (inc && !dec)
          cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
        else if (dec && !inc)
          cnt_q[i] <= cnt_q[i] - CNT_WIDTH'(1);
        if (inc && !hit)
          sid_q[i] <= up_req_id;
      end
      if (rsp_hs && cnt_q[dn_rsp_id] == '0)
        bad_q <= 1'b1;
    end
  end

endmodule

// File: doc/axi_id_remap.md
AXI_ID_REMAP -- requirements
Module: axi_id_remap

Interface
- REQ-001 Parameter IN_ID_WIDTH, default 6: upstream ID width, i.e. master ID width + log2(MASTER_NUM) as produced by the crossbar slave port.
- REQ-002 Parameter OUT_ID_WIDTH, default 2: downstream ID width; table holds 2**OUT_ID_WIDTH entries.
- REQ-003 Parameter CNT_WIDTH, default 3: per-entry outstanding counter width; max outstanding per entry = 2**CNT_WIDTH-1.
- REQ-004 Parameter REQ_WIDTH, default 64: opaque request payload width (AR or AW fields minus ID).
- REQ-005 Parameter RSP_WIDTH, default 66: opaque response payload width (R or B fields minus ID and last).
- REQ-006 clk  input  1  clock; all state updates on rising edge.
- REQ-007 rstn  input  1  reset, synchronous, active-low.
- REQ-008 up_req_valid/up_req_ready  input/output  1/1  upstream request handshake.
- REQ-009 up_req_id/up_req_data  input  IN_ID_WIDTH/REQ_WIDTH  upstream request ID and payload.
- REQ-010 dn_req_valid/dn_req_ready  output/input  1/1  downstream request handshake.
- REQ-011 dn_req_id/dn_req_data  output  OUT_ID_WIDTH/REQ_WIDTH  remapped ID; payload passed unmodified.
- REQ-012 dn_rsp_valid/dn_rsp_ready  input/output  1/1  downstream response handshake.
- REQ-013 dn_rsp_id/dn_rsp_last/dn_rsp_data  input  OUT_ID_WIDTH/1/RSP_WIDTH  response ID, last beat (tie 1 for B), payload.
- REQ-014 up_rsp_valid/up_rsp_ready  output/input  1/1  upstream response handshake.
- REQ-015 up_rsp_id/up_rsp_last/up_rsp_data  output  IN_ID_WIDTH/1/RSP_WIDTH  restored ID, last, payload.
- REQ-016 bad_rsp  output  1  sticky flag: response received for an inactive entry.

Function
- REQ-017 Block SHALL hold per entry: active bit, stored IN ID, CNT_WIDTH counter; entry active iff counter != 0.
- REQ-018 Request path SHALL be combinational, zero added latency: dn_req_valid = up_req_valid & accept_ok; up_req_ready = dn_req_ready & accept_ok.
- REQ-019 accept_ok SHALL depend only on table state and up_req_id, never on dn_req_ready.
- REQ-020 Hit (active entry with stored ID == up_req_id): dn_req_id = that entry; accept_ok = counter < max.
- REQ-021 Miss: dn_req_id = lowest-index inactive entry; accept_ok = 0 if no inactive entry.
- REQ-022 At most one entry SHALL ever be active per IN ID, preserving same-ID ordering.
- REQ-023 On request handshake, chosen entry counter SHALL increment; on miss, stored ID loaded with up_req_id.
- REQ-024 Response path SHALL be combinational: up_rsp_valid = dn_rsp_valid; dn_rsp_ready = up_rsp_ready; up_rsp_id = stored ID of entry dn_rsp_id; last/data pass through.
- REQ-025 On response handshake with last=1 to an active entry, counter SHALL decrement; non-last beats SHALL not change state.
- REQ-026 Same-cycle request and last-response on the same entry: counter unchanged, entry stays active, stored ID kept.
- REQ-027 Entry freed by last-response in cycle N SHALL be allocatable from cycle N+1, not in cycle N.
- REQ-028 Response handshake to an inactive entry: no counter change, up_rsp_id = stale stored ID, bad_rsp set until reset.

Reset
- REQ-029 While rstn=0 at clk edge: all counters 0, stored IDs 0, bad_rsp 0.
- REQ-030 During reset, up_req_ready and dn_req_valid SHALL be 0 (no entry allocatable); response path remains combinational but causes no state change.
- REQ-031 Reset mid-transaction SHALL discard all table state; no outstanding tracking survives.

Verification
- REQ-032 Requests ID 0x05, 0x05, 0x2A, dn ready -> dn IDs 0,0,1; counters e0=2, e1=1.
- REQ-033 Four distinct IDs 0x01..0x04 outstanding, request 0x09 -> up_req_ready=0, dn_req_valid=0 until a last-response frees an entry, then 0x09 takes that index next cycle.
- REQ-034 Seven requests ID 0x11 (CNT_WIDTH=3) -> eighth stalled; one last-response on e0 -> eighth accepted next cycle.
- REQ-035 4-beat R burst on dn ID 1 (stored 0x2A) with up_rsp_ready toggling -> every beat up_rsp_id=0x2A, counter decrements only on last handshake.
- REQ-036 Same-cycle request ID 0x05 and last-response on its entry (count 1) -> count stays 1, entry keeps 0x05; response to inactive entry 3 -> bad_rsp=1 and stays 1.
